// File: rtl/pipe_rng_scheduler.sv
// ============================================================================
// Module   : pipe_rng_scheduler
// Brief    : 4-bit game LFSR shared by the pipe spawner and one auxiliary
//            consumer through a single round-robin grant. It also times pipe
//            spawns from frame ticks. Optional macro PIPE_RNG_SEED_EN adds a
//            seed load port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_rng_scheduler #(
  parameter int SPAWN_INTERVAL = 48,
  parameter int GAP_MIN        = 2,
  parameter int GAP_MAX        = 12
) (
  input  logic       clock,
  input  logic       reset,
`ifdef PIPE_RNG_SEED_EN
  input  logic [3:0] seed,
  input  logic       seed_load,
`endif
  input  logic       tick,
  input  logic       run,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic [3:0] rnd,
  output logic       spawn,
  output logic [3:0] gap_row,
  output logic       busy
);

  localparam logic [7:0] C_CNT_LAST = 8'(SPAWN_INTERVAL - 1);
  localparam logic [3:0] C_GAP_MIN  = 4'(GAP_MIN);
  localparam logic [3:0] C_GAP_MAX  = 4'(GAP_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_SPAWN = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic       w_spawn_draw;

  logic [3:0] r_lfsr;
  logic [3:0] w_lfsr_step;
  logic [3:0] w_lfsr_next;
  logic       w_seed_load;
  logic [3:0] w_seed_val;

  // r_last_hi==1 means req[1] was granted last, so req[0] wins the next tie
  logic       r_last_hi;
  logic [1:0] w_gnt_next;
  logic [1:0] r_gnt;
  logic [3:0] r_rnd;
  logic [3:0] r_gap_row;

  function automatic logic [3:0] clamp_gap(input logic [3:0] x);
    if (x < C_GAP_MIN) begin
      return C_GAP_MIN;
    end else if (x > C_GAP_MAX) begin
      return C_GAP_MAX;
    end
    return x;
  endfunction

  // ---------------------------------------------------------------- LFSR
  always_comb begin
    w_lfsr_step = (r_lfsr == 4'hF) ? 4'h0
                                   : {r_lfsr[2:0], ~(r_lfsr[3] ^ r_lfsr[2])};
  end

`ifdef PIPE_RNG_SEED_EN
  always_comb begin
    w_seed_load = seed_load;
    w_seed_val  = (seed == 4'hF) ? 4'h0 : seed;
  end
`else
  always_comb begin
    w_seed_load = 1'b0;
    w_seed_val  = 4'h0;
  end
`endif

  always_comb begin
    w_lfsr_next = w_seed_load ? w_seed_val : w_lfsr_step;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_lfsr <= 4'h0;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_spawn_draw = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = 8'd0;
        if (run) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        // losing run wins over a coincident tick
        if (!run) begin
          w_state_next = S_IDLE;
          w_cnt_next   = 8'd0;
        end else if (tick) begin
          if (r_cnt == C_CNT_LAST) begin
            w_spawn_draw = 1'b1;
            w_cnt_next   = 8'd0;
            w_state_next = S_SPAWN;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
      end
      S_SPAWN: begin
        if (!run) begin
          w_state_next = S_IDLE;
          w_cnt_next   = 8'd0;
        end else begin
          w_state_next = S_RUN;
          if (tick) begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  // ------------------------------------------------------------- Arbiter
  // The spawn draw owns the LFSR value in its cycle, so requests stall.
  always_comb begin
    w_gnt_next = 2'b00;
    if (!w_spawn_draw) begin
      case (req)
        2'b01:   w_gnt_next = 2'b01;
        2'b10:   w_gnt_next = 2'b10;
        2'b11:   w_gnt_next = r_last_hi ? 2'b01 : 2'b10;
        default: w_gnt_next = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_gnt     <= 2'b00;
      r_rnd     <= 4'h0;
      r_last_hi <= 1'b1;
      r_gap_row <= 4'h0;
    end else begin
      r_gnt     <= w_gnt_next;
      r_rnd     <= (|w_gnt_next) ? r_lfsr : 4'h0;
      if (|w_gnt_next) begin
        r_last_hi <= w_gnt_next[1];
      end
      r_gap_row <= w_spawn_draw ? clamp_gap(r_lfsr) : 4'h0;
    end
  end

  assign gnt     = r_gnt;
  assign rnd     = r_rnd;
  assign gap_row = r_gap_row;
  assign spawn   = (r_state == S_SPAWN);
  assign busy    = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/pipe_rng_scheduler.md
# pipe_rng_scheduler

Owns the 4-bit game LFSR and shares it between the pipe spawner and one auxiliary consumer. Every random draw goes through a single arbitrated grant, so no two consumers ever receive the same value. The block also times pipe spawns from frame ticks and emits a clamped gap row with each spawn. It sits between the frame-tick generator and the pipe/obstacle logic in the Flappy top level.

## Interface
- SPAWN_INTERVAL, 48, frame ticks between pipe spawns (legal range 2..255)
- GAP_MIN, 2, lowest legal gap row (0..15)
- GAP_MAX, 12, highest legal gap row (GAP_MIN..15)

- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-low; reset==0 at a posedge clears all state
- tick  in  1  one-cycle frame-tick pulse
- run  in  1  game active level
- req  in  2  random-value requests; bit 0 is the pipe colour/variant, bit 1 is aux
- gnt  out  2  one-hot grant pulse, 1 cycle
- rnd  out  4  random value, valid only while gnt != 0
- spawn  out  1  one-cycle pipe-spawn pulse
- gap_row  out  4  clamped gap row, valid only while spawn==1
- busy  out  1  high in state RUN or SPAWN

## Operation
- **LFSR**
  - Internal 4-bit state L advances every clock while reset==1.
  - Next state is {L[2:0], ~(L[3]^L[2])}.
  - Reset value is 0000, giving a 15-state sequence starting 0000, 0001, 0011, 0111, 1110, 1101, ...
  - L==1111 is the lockup state. If it is ever present, the next state is forced to 0000.
- **FSM states: IDLE, RUN, SPAWN.** Reset state is IDLE.
  - IDLE: the tick counter C is held at 0. Move to RUN when run==1.
  - RUN: tick increments C. If tick arrives while C==SPAWN_INTERVAL-1, clear C, latch G=clamp(L), and move to SPAWN. If run==0, move to IDLE and clear C. The run==0 check has priority over the tick.
  - SPAWN: lasts exactly one cycle, with spawn=1 and gap_row=G. Next state is RUN, or IDLE if run==0. A tick arriving during SPAWN increments C to 1.
  - clamp(x) = GAP_MIN if x<GAP_MIN; GAP_MAX if x>GAP_MAX; otherwise x.
- **Arbitration**
  - Round-robin between req[0] and req[1] using a last-grant pointer P. Reset value of P favours req[0].
  - Requests are served in every state, including IDLE.
  - A spawn draw has absolute priority. In the cycle where the FSM latches G (RUN→SPAWN transition), no grant is issued and pending requests wait.
  - At most one grant per cycle. A requester holds req until it sees its gnt bit.
  - Keeping req high after gnt counts as a new request, subject to round-robin.
  - Each draw returns a different L value, since L advances every cycle.
- Reset values: gnt=00, rnd=0000, spawn=0, gap_row=0000, busy=0, C=0, P→req[0], L=0000.

## Timing
- Grant latency is 1 cycle. If req is sampled at posedge n, gnt and rnd are registered and appear after posedge n+1, with rnd equal to L as it was in cycle n.
- Spawn latency is 1 cycle. The qualifying tick is sampled at posedge n. spawn and gap_row are high for the cycle after posedge n+1, and G is clamp(L in cycle n).
- With run held high and ticks present, spawn pulses occur exactly every SPAWN_INTERVAL ticks. The first spawn comes SPAWN_INTERVAL ticks after entering RUN.
- A reset asserted mid-operation takes effect at the same posedge. Any pending grant or spawn is discarded, and all outputs return to reset values in the following cycle.
- If both requests arrive in the same cycle as a spawn draw, both are stalled one cycle. They are then served over consecutive cycles in round-robin order.

## Configuration
- Macro name: PIPE_RNG_SEED_EN.
- **Defined:**
  - Adds input ports seed (4 bits) and seed_load (1 bit).
  - seed_load==1 at a posedge sets L to seed, overriding the normal advance.
  - A seed of 1111 loads as 0000.
  - Reset still has priority over seed_load.
- **Undefined:** the ports are absent and L is only ever initialised by reset.

## Test plan
- Reset LFSR sequence: release reset and hold req=00, run=0. L must walk 0000, 0001, 0011, 0111, 1110, 1101, 1011 and return to 0000 after 15 steps. All outputs stay 0.
- Single grant: assert req=01 in the first cycle after reset release. The next cycle must show gnt=01 and rnd=0000. With req held, the following grant shows rnd=0001.
- Round-robin: hold req=11 continuously. gnt must alternate 01, 10, 01, ..., starting with 01, and never be 11 or issue two grants in one cycle.
- Spawn timing: SPAWN_INTERVAL=4, run=1, tick every cycle.
  - spawn pulses once every 4 ticks.
  - When the spawn draw sees L=0000, gap_row=2; when it sees L=1110, gap_row=12.
  - If run drops mid-count, C is cleared and no spawn occurs.
- Spawn vs request collision: req=10 asserted in the same cycle as the spawn draw. No gnt in the SPAWN cycle. gnt=10 the cycle after, with a non-stale rnd.
- Mid-operation reset: assert reset=0 while in SPAWN with req=11 pending. The next cycle must show spawn=0, gnt=00, busy=0. After release, L restarts at 0000 and the first grant goes to req[0].
